// File: rtl/pd_rx_fifo.sv
// First-word-fall-through receive FIFO for packet-data beats with byte masks.
// Link-down flushes all control state; overflow is a sticky dropped-beat flag.
module pd_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 512
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic                         linkup,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [DATA_W/8-1:0]          wr_mask,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic [DATA_W/8-1:0]          rd_mask,
  output logic [6:0]                   rd_bytes,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int MW = DATA_W / 8;

  function automatic logic [6:0] popcnt(input logic [MW-1:0] m);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MW; i++) begin
      cnt = cnt + 7'(m[i]);
    end
    return cnt;
  endfunction

  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [MW-1:0]     mask_mem  [DEPTH];
  logic [6:0]        bytes_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;

  logic          pop;
  logic          push_req;
  logic          push;
  logic          drop;
  logic [6:0]    wr_bytes;

  assign pop      = linkup && !empty_q && rd_ready;
  assign push_req = linkup && wr_en && (wr_mask != '0);
  assign push     = push_req && (!full_q || pop);
  assign drop     = push_req && full_q && !pop;
  // Byte count is computed on the way in so the read side is a plain lookup.
  assign wr_bytes = popcnt(wr_mask);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else if (!linkup) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge pclk) begin
    if (push) begin
      data_mem[wr_ptr_q]  <= wr_data;
      mask_mem[wr_ptr_q]  <= wr_mask;
      bytes_mem[wr_ptr_q] <= wr_bytes;
    end
  end

  assign rd_valid = !empty_q;
  assign rd_data  = data_mem[rd_ptr_q];
  assign rd_mask  = empty_q ? '0 : mask_mem[rd_ptr_q];
  assign rd_bytes = empty_q ? 7'd0 : bytes_mem[rd_ptr_q];
  assign level    = level_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: doc/pd_rx_fifo.md
PD_RX_FIFO -- requirements
Module: pd_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of beat entries; power of two, 2..64.
REQ-002 SHALL have parameter DATA_W, default 512, beat data width; byte-mask width is DATA_W/8 (64 at default).
REQ-003 SHALL have port pclk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port linkup  input  1  link-up qualifier; low flushes the buffer.
REQ-006 SHALL have port wr_en  input  1  write strobe, driven by the generation controller's w output.
REQ-007 SHALL have port wr_data  input  DATA_W  beat data.
REQ-008 SHALL have port wr_mask  input  DATA_W/8  byte-lane valid mask, driven by the generation controller's valid output.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts head beat.
REQ-010 SHALL have port rd_valid  output  1  head beat present.
REQ-011 SHALL have port rd_data  output  DATA_W  head beat data.
REQ-012 SHALL have port rd_mask  output  DATA_W/8  head beat byte mask.
REQ-013 SHALL have port rd_bytes  output  7  population count of rd_mask.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  stored beat count.
REQ-015 SHALL have ports full, empty  output  1 each  occupancy flags.
REQ-016 SHALL have port overflow  output  1  sticky dropped-write flag.

Function
REQ-017 SHALL be first-word-fall-through: rd_data/rd_mask/rd_bytes reflect the head entry combinationally from storage; rd_valid = !empty.
REQ-018 SHALL pop when rd_valid && rd_ready; pop with rd_valid low SHALL have no effect.
REQ-019 SHALL push when linkup && wr_en && (wr_mask != 0) && (!full || pop in same cycle).
REQ-020 SHALL drop wr_en beats whose wr_mask is all-zero, without touching overflow.
REQ-021 SHALL, on linkup && wr_en && wr_mask != 0 && full && no pop, drop the beat and set overflow.
REQ-022 SHALL keep overflow set until reset or linkup low.
REQ-023 SHALL update level by +1 on push only, -1 on pop only, 0 on push+pop.
REQ-024 SHALL assert full when level == DEPTH and empty when level == 0, both registered with level.
REQ-025 SHALL wrap write/read pointers modulo DEPTH; a write at pointer DEPTH-1 is followed by pointer 0.
REQ-026 SHALL make a written beat visible at rd_valid on the cycle after the push edge (1-cycle latency).
REQ-027 SHALL, while linkup is low, reset pointers and level to 0, clear overflow, ignore wr_en and rd_ready; rd_valid SHALL be 0 from the next edge.
REQ-028 SHALL drive rd_bytes = 0 and rd_mask = 0 when empty; rd_data is don't-care when empty.
REQ-029 SHALL compute rd_bytes as an unsigned 7-bit count (max 64) without truncation at DATA_W=512.
REQ-030 SHALL not require storage contents to be reset; only control state is reset.

Reset
REQ-031 SHALL, while reset is high, hold level=0, empty=1, full=0, rd_valid=0, rd_bytes=0, rd_mask=0, overflow=0, pointers=0.
REQ-032 SHALL discard any stored beats when reset asserts mid-operation; first push after reset release is entry 0.

Verification
REQ-033 SHALL cover: reset, linkup=1, one write wr_mask=0x0000_0000_0000_00FF, rd_ready=0 -> next cycle rd_valid=1, rd_bytes=8, level=1.
REQ-034 SHALL cover: DEPTH=8, 9 consecutive writes mask=0xFFFF, rd_ready=0 -> level=8, full=1, 9th dropped, overflow=1; 8 pops return beats 1..8 in order.
REQ-035 SHALL cover: full FIFO, simultaneous write and pop -> level stays 8, overflow stays 0, new beat read last.
REQ-036 SHALL cover: 3 beats stored, overflow=1, linkup pulled low one cycle -> level=0, empty=1, overflow=0; wr_en during low ignored.
REQ-037 SHALL cover: wr_en=1 with wr_mask=0 -> level unchanged, overflow unchanged.
REQ-038 SHALL cover: 20 write/pop pairs with random masks (incl. all-ones -> rd_bytes=64) -> pointer wrap, data and rd_bytes match scoreboard.
